// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller slice.
package pipe_pkg;
   typedef logic [4:0] reg_idx_t;

   localparam reg_idx_t    REG_ZERO         = 5'd0;
   localparam logic [1:0]  MEMREAD_NONE     = 2'b00;
   localparam int unsigned MULT_LAT_DEFAULT = 4;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ID-stage hazard bundle between pipeline datapath (master) and controller (slave).
// HAZ_STATS_EN adds the StallCycles/FlushCount statistics outputs.
interface pipeline_hazard_ctrl_if;
   import pipe_pkg::*;

   reg_idx_t    IDRs;
   reg_idx_t    IDRt;
   logic        IDUsesRt;
   logic        IDHLOp;
   logic [1:0]  EXMemRead;
   logic        EXRegWrite;
   reg_idx_t    EXDst;
   logic        EXHLStart;
   logic        BranchTaken;
   logic        PCWrite;
   logic        IFIDWrite;
   logic        IFIDFlush;
   logic        IDEXBubble;
   logic        HLBusy;
`ifdef HAZ_STATS_EN
   logic [31:0] StallCycles;
   logic [31:0] FlushCount;
`endif

   modport master (
      output IDRs, IDRt, IDUsesRt, IDHLOp, EXMemRead, EXRegWrite, EXDst,
             EXHLStart, BranchTaken,
      input  PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, HLBusy
`ifdef HAZ_STATS_EN
      , input StallCycles, FlushCount
`endif
   );

   modport slave (
      input  IDRs, IDRt, IDUsesRt, IDHLOp, EXMemRead, EXRegWrite, EXDst,
             EXHLStart, BranchTaken,
      output PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, HLBusy
`ifdef HAZ_STATS_EN
      , output StallCycles, FlushCount
`endif
   );
endinterface

// File: rtl/pipeline_hazard_ctrl_hl_busy_timer.sv
// HI/LO busy timer: loadable down-counter, busy for LAT cycles after Start.
module hl_busy_timer #(
   parameter int unsigned LAT = 4
) (
   input  logic Clk,
   input  logic Rst_n,
   input  logic Start,
   output logic Busy
);
   localparam int unsigned     CNT_W      = $clog2(LAT + 1);
   localparam logic [CNT_W-1:0] LOAD      = CNT_W'(LAT);
   localparam logic [0:0]       ST_RUN     = 1'b0;
   localparam logic [0:0]       ST_HL_BUSY = 1'b1;

   logic [CNT_W-1:0] r_cnt;
   logic [0:0]       w_state;

   // Start reloads even mid-count; a new mult/div restarts the full latency.
   always_ff @(posedge Clk) begin
      if (!Rst_n)
         r_cnt <= '0;
      else if (Start)
         r_cnt <= LOAD;
      else if (r_cnt != '0)
         r_cnt <= r_cnt - CNT_W'(1);
   end

   assign w_state = (r_cnt != '0) ? ST_HL_BUSY : ST_RUN;
   assign Busy    = (w_state == ST_HL_BUSY);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for IF/ID and ID/EX: load-use, HI/LO-use stalls and branch flush.
// HAZ_STATS_EN adds saturating stall/flush cycle counters.
module pipeline_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned MULT_LAT = MULT_LAT_DEFAULT
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   pipeline_hazard_ctrl_if.slave hz
);
   localparam int unsigned      CNT_W   = $clog2(MULT_LAT + 1);
   localparam logic [CNT_W-1:0] HL_LOAD = CNT_W'(MULT_LAT);

   logic w_busy;
   logic w_load_use;
   logic w_hl_use;
   logic w_pcwrite;
   logic w_ifidwrite;
   logic w_flush;
   logic w_bubble;

   hl_busy_timer #(.LAT(32'(HL_LOAD))) u_hl_timer (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .Start (hz.EXHLStart),
      .Busy  (w_busy)
   );

   assign w_load_use = (hz.EXMemRead != MEMREAD_NONE) & hz.EXRegWrite &
                       (hz.EXDst != REG_ZERO) &
                       ((hz.EXDst == hz.IDRs) | (hz.IDUsesRt & (hz.EXDst == hz.IDRt)));
   assign w_hl_use   = w_busy & hz.IDHLOp;

   // Branch wins over stalls: the ID instruction is wrong-path and gets flushed anyway.
   always_comb begin
      w_pcwrite   = 1'b1;
      w_ifidwrite = 1'b1;
      w_flush     = 1'b0;
      w_bubble    = 1'b0;
      if (Rst_n) begin
         if (hz.BranchTaken) begin
            w_flush  = 1'b1;
            w_bubble = 1'b1;
         end else if (w_load_use | w_hl_use) begin
            w_pcwrite   = 1'b0;
            w_ifidwrite = 1'b0;
            w_bubble    = 1'b1;
         end
      end
   end

   assign hz.PCWrite    = w_pcwrite;
   assign hz.IFIDWrite  = w_ifidwrite;
   assign hz.IFIDFlush  = w_flush;
   assign hz.IDEXBubble = w_bubble;
   assign hz.HLBusy     = Rst_n & w_busy;

`ifdef HAZ_STATS_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (!w_pcwrite && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + 32'd1;
         if (w_flush && r_flush_cnt != '1)
            r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end

   assign hz.StallCycles = r_stall_cnt;
   assign hz.FlushCount  = r_flush_cnt;
`endif
endmodule
